// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl / ha
//
// Bit-serial adder controller. One 1-bit full-adder cell is reused over
// WIDTH clock cycles to add two WIDTH-bit operands. The cell is two half
// adders plus an OR gate. Bits are processed LSB first, and a carry
// flip-flop links each cycle to the next. The design uses one cell
// instead of a WIDTH-bit adder, so each result takes longer to produce.
//
// Ports (serial_adder_ctrl):
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   a/b/cin operand set is valid
//   in_ready   block can accept operands (high only in IDLE)
//   a, b       WIDTH-bit operands
//   cin        carry-in
//   out_valid  result is valid (high only in DONE)
//   out_ready  consumer accepts the result
//   sum        registered (a+b+cin) mod 2^WIDTH
//   cout       registered carry-out
//   busy       high whenever the controller is not in IDLE
//
// Ports (ha): x, y inputs; s = x^y, c = x&y.

module ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    // Full-adder cell: first half adder adds the operand bits, second adds
    // the running carry. At most one half adder can carry, so OR is enough.
    logic s0, c0, c1;
    logic cell_s, cell_c;

    ha u_ha0 (.x(a_sh[0]), .y(b_sh[0]), .s(s0),     .c(c0));
    ha u_ha1 (.x(s0),      .y(carry),   .s(cell_s), .c(c1));

    assign cell_c = c0 | c1;

    // New sum bit enters at the MSB so that after WIDTH shifts the LSB-first
    // bits line up. Written as shift/OR so WIDTH=1 needs no special slice.
    logic [WIDTH-1:0] sum_next;

    always_comb begin
        sum_next = (sum_sh >> 1) | (WIDTH'(cell_s) << (WIDTH - 1));
    end

    assign busy = (state != IDLE);

    // Controller FSM. It also registers the handshake outputs and the
    // result, so they change only on clock edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            carry     <= 1'b0;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        carry    <= cin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    carry  <= cell_c;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_next;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum       <= sum_next;
                        cout      <= cell_c;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
